seq_muldiv: RTL and testbench
=============================

# seq_muldiv

Parametrised iterative multiply/divide unit. It is the next generation of the team's serial `multdiv` and keeps the same operand and result conventions. It adds configurable operand width, configurable bits retired per cycle, a `busy` flag, a synchronous `abort` for pipeline flushes, early exit on divide-by-zero, and result registers that hold their value while a new operation runs. It sits beside the integer datapath and serves MULT/MULTU/DIV/DIVU, writing HI (`prodh`) and LO (`prodl`).

## Interface
- `WIDTH`, default 32: operand width; even, ≥ 8.
- `BITS_PER_CYCLE`, default 1: bits retired per iteration; one of 1, 2, 4; must divide `WIDTH`.
- Derived `N = WIDTH / BITS_PER_CYCLE`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `abort`  in  1  synchronous cancel of the in-flight operation.
- `multdivb`  in  1  1 = multiply, 0 = divide.
- `signedop`  in  1  1 = two's-complement operands.
- `x`  in  WIDTH  multiplicand / dividend.
- `y`  in  WIDTH  multiplier / divisor.
- `prodh`  out  WIDTH  product high half / remainder.
- `prodl`  out  WIDTH  product low half / quotient.
- `done`  out  1  result valid (level).
- `busy`  out  1  operation in flight.
- `dividebyzero`  out  1  last completed divide had `y == 0`.

## Operation
- States:
  - IDLE: initial state.
  - RUN: N iterations, iteration counter 0..N-1.
  - FIX: one cycle; applies sign correction and loads the result registers.
  - DONE: result held.
- Transitions:
  - IDLE/DONE → RUN on `start` (and no `abort`).
  - IDLE/DONE → DONE on `start` with divide and `y == 0` (early exit).
  - RUN → FIX when the counter reaches N-1.
  - FIX → DONE.
  - Any state → IDLE on `abort` or `reset`.
- Operand capture: `x`, `y`, `multdivb` and `signedop` are sampled only on the accepting edge. Later input changes are ignored.
- Multiply: `{prodh,prodl}` = full 2·WIDTH product. When `signedop` = 1, operands are sign-extended and the product is taken in two's complement.
- Divide:
  - `prodl` = quotient, truncated toward zero.
  - `prodh` = remainder; its sign follows the dividend, and |rem| < |y|.
  - Signed overflow (min-int / -1): quotient = min-int, remainder = 0, `dividebyzero` = 0.
- Divide-by-zero: `dividebyzero` = 1, `prodl` = all ones, `prodh` = `x` (raw), no iterations run.
- Internally, operations are computed on magnitudes; FIX negates results as required.
- `prodh`/`prodl` change only on the edge that raises `done`. They hold the previous result through RUN, after `abort`, and after a rejected `start`.
- `start` while `busy` is ignored; no queueing.
- `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.
- `dividebyzero` updates together with `done` and is cleared on the accepting edge of the next `start`.

## Timing
- Reset: state IDLE, `prodh` = 0, `prodl` = 0, `done` = 0, `busy` = 0, `dividebyzero` = 0.
- Let E0 be the edge that accepts `start`.
  - `busy` = 1 and `done` = 0 after E0.
  - Normal operation: RUN occupies edges E0+1..E0+N, FIX is E0+N+1, and `done` rises / `busy` falls at E0+N+2.
  - Divide-by-zero: `done` = 1 and `dividebyzero` = 1 at E0+1; `busy` never rises.
- Latency:
  - `WIDTH`=32, `BITS_PER_CYCLE`=1: 34 cycles.
  - `BITS_PER_CYCLE`=2: 18 cycles.
  - `BITS_PER_CYCLE`=4: 10 cycles.
  - Latency is independent of operand values, except for divide-by-zero.
- `done` remains high until the next accepted `start`, an `abort`, or `reset`.
- Back-to-back: `start` held high in DONE launches the next operation on the following edge. `done` drops after that edge; the previous result stays on `prodh`/`prodl` until the new result lands.
- `abort` at any edge: IDLE and `busy` = `done` = 0 after that edge; no partial result is written.
- `reset` mid-operation: all outputs return to reset values on the next edge.

## Test plan
- `WIDTH`=32, P=1, unsigned multiply FFFFFFFF × FFFFFFFF → `prodh`=FFFFFFFE, `prodl`=00000001; `done` at E0+34 and not before; `busy` high E0+1..E0+33.
- Signed multiply 80000000 × FFFFFFFF → 00000000_80000000. Signed divide FFFFFFF9 / 00000002 → `prodl`=FFFFFFFD, `prodh`=FFFFFFFF. Signed divide 80000000 / FFFFFFFF → `prodl`=80000000, `prodh`=0.
- Divide ABCDEF01 / 0 with `signedop` = 0 and = 1 → `done`+`dividebyzero` at E0+1, `prodl`=FFFFFFFF, `prodh`=ABCDEF01. A following divide 00000064 / 00000007 clears `dividebyzero` and gives `prodl`=0E, `prodh`=02.
- Flush and reset:
  - `abort` at E0+10 of a multiply → `busy`/`done` = 0 and `prodh`/`prodl` keep the prior result.
  - `start` at E0+5 with new operands is ignored; the result matches the original operands.
  - `reset` at E0+20 → all outputs 0.
- Sweep `BITS_PER_CYCLE` ∈ {1, 2, 4} × `WIDTH` ∈ {8, 32}:
  - Corner operands 0, 1, 2, 7F..F, 80..0, FF..FE, FF..F, plus 23456789 and ABCDEF01 (for `WIDTH`=32), all four signed/op combinations, checked against a behavioural model.
  - Latency must equal N+2.
- Back-to-back: 100 random operations with `start` asserted in the same cycle `done` is seen → no lost or duplicated results; each result is visible for ≥ 1 cycle.

Source files
------------

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, BITS_PER_CYCLE bits retired per iteration, sign fix-up in a final cycle.
module seq_muldiv #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             multdivb,
  input  logic             signedop,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] prodh,
  output logic [WIDTH-1:0] prodl,
  output logic             done,
  output logic             busy,
  output logic             dividebyzero
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned P  = BITS_PER_CYCLE;
  localparam int unsigned N  = W / P;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            op_mul, neg_q, neg_r;
  logic [W-1:0]    opnd;   // multiplicand magnitude, or divisor magnitude
  logic [W-1:0]    hi, lo; // product high/low, or partial remainder / quotient

  logic            accept, zero_div;
  logic [W-1:0]    x_mag, y_mag;
  logic [W+P-1:0]  mul_sum;
  logic [W:0]      trial;
  logic [W-1:0]    div_r, div_q;
  logic [W-1:0]    hi_nx, lo_nx;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    q_fix, r_fix;

  always_comb begin
    accept   = start && !abort && (state == IDLE || state == DONE);
    zero_div = !multdivb && (y == '0);
    x_mag    = (signedop && x[W-1]) ? -x : x;
    y_mag    = (signedop && y[W-1]) ? -y : y;
  end

  // One iteration: multiply adds opnd * P multiplier bits and shifts the pair right;
  // divide shifts P dividend bits into the remainder with one trial subtract each.
  always_comb begin
    mul_sum = {{P{1'b0}}, hi} + ({{P{1'b0}}, opnd} * {{W{1'b0}}, lo[P-1:0]});
    div_r   = hi;
    div_q   = lo;
    trial   = '0;
    for (int unsigned i = 0; i < P; i++) begin
      trial = {div_r, div_q[W-1]};
      div_q = {div_q[W-2:0], 1'b0};
      if (trial >= {1'b0, opnd}) begin
        trial    = trial - {1'b0, opnd};
        div_q[0] = 1'b1;
      end
      div_r = trial[W-1:0];
    end
    if (op_mul) begin
      hi_nx = mul_sum[W+P-1:P];
      lo_nx = {mul_sum[P-1:0], lo[W-1:P]};
    end else begin
      hi_nx = div_r;
      lo_nx = div_q;
    end
  end

  always_comb begin
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    q_fix    = neg_q ? -lo : lo;
    r_fix    = neg_r ? -hi : hi;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = zero_div ? DONE : RUN;
      RUN:        if (cnt == CW'(N - 1)) state_nx = FIX;
      FIX:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      op_mul       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      opnd         <= '0;
      hi           <= '0;
      lo           <= '0;
      prodh        <= '0;
      prodl        <= '0;
      dividebyzero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_mul       <= multdivb;
        cnt          <= '0;
        hi           <= '0;
        lo           <= multdivb ? y_mag : x_mag;
        opnd         <= multdivb ? x_mag : y_mag;
        neg_q        <= signedop && (x[W-1] ^ y[W-1]);
        neg_r        <= signedop && x[W-1];
        dividebyzero <= zero_div;
        if (zero_div) begin
          prodh <= x;
          prodl <= '1;
        end
      end else if (!abort) begin
        if (state == RUN) begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
        end
        if (state == FIX) begin
          if (op_mul) begin
            {prodh, prodl} <= prod_fix;
          end else begin
            prodh <= r_fix;
            prodl <= q_fix;
          end
        end
      end
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv: six instances (WIDTH 32/8 x BITS_PER_CYCLE 1/2/4)
// share stimulus; instance 0 (32-bit, one bit per cycle) carries the timing scenarios.
module tb_seq_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, abort, multdivb, signedop;
  logic [31:0] xin, yin;
  logic [31:0] ph [6];
  logic [31:0] pl [6];
  logic        dn [6];
  logic        bs [6];
  logic        dz [6];
  int          nchk = 0;
  int          nfail = 0;
  int          lat [6];
  int          bcnt [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int unsigned W = (g < 3) ? 32 : 8;
    localparam int unsigned P = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
    logic [W-1:0] h, l;
    logic         d, b, z;
    seq_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(P)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .multdivb(multdivb), .signedop(signedop),
      .x(xin[W-1:0]), .y(yin[W-1:0]),
      .prodh(h), .prodl(l), .done(d), .busy(b), .dividebyzero(z)
    );
    assign ph[g] = 32'(h);
    assign pl[g] = 32'(l);
    assign dn[g] = d;
    assign bs[g] = b;
    assign dz[g] = z;
  end

  function automatic int width_of(input int g);
    return (g < 3) ? 32 : 8;
  endfunction

  function automatic int n_of(input int g);
    return width_of(g) / ((g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4));
  endfunction

  // Reference built on native 64-bit arithmetic; returns {prodh, prodl} zero-extended.
  function automatic logic [63:0] model(input logic mul, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input int w);
    logic [31:0] mask, ua, ub, hi, lo;
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    ua = a & mask;
    ub = b & mask;
    if (sgn && w == 32) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else if (sgn) begin
      sa = longint'($signed(a[7:0]));
      sb = longint'($signed(b[7:0]));
    end else begin
      sa = longint'({32'h0, ua});
      sb = longint'({32'h0, ub});
    end
    hi = '0;
    lo = '0;
    if (mul) begin
      p  = sa * sb;
      pu = p;
      hi = (w == 32) ? pu[63:32] : {24'h0, pu[15:8]};
      lo = pu[31:0] & mask;
    end else if (ub == 32'h0) begin
      hi = ua;
      lo = mask;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      pu = q;
      lo = pu[31:0] & mask;
      pu = r;
      hi = pu[31:0] & mask;
    end
    return {hi, lo};
  endfunction

  // Launch one operation on all instances; lat[g] is the k of the first "after E0+k-1"
  // sample (k=1 right after E0) with done high, bcnt[g] counts busy samples before it.
  task automatic run_op(input logic mul, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b);
    bit all_seen;
    @(negedge clk);
    multdivb = mul; signedop = sgn; xin = a; yin = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; multdivb = ~mul; signedop = ~sgn; xin = ~a; yin = ~b;
    for (int g = 0; g < 6; g++) begin
      lat[g]  = -1;
      bcnt[g] = 0;
    end
    for (int k = 1; k <= 60; k++) begin
      all_seen = 1'b1;
      for (int g = 0; g < 6; g++) begin
        if (lat[g] < 0) begin
          if (dn[g]) lat[g] = k;
          else begin
            if (bs[g]) bcnt[g]++;
            all_seen = 1'b0;
          end
        end
      end
      if (all_seen) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      nchk++;
      if ({ph[g], pl[g], dn[g], bs[g], dz[g]} !== 67'h0) begin
        nfail++;
        $display("FAIL reset g%0d: got h=%h l=%h done=%b busy=%b dbz=%b expected all zero",
                 g, ph[g], pl[g], dn[g], bs[g], dz[g]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_mul_unsigned();
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    nchk++;
    if (ph[0] !== 32'hFFFF_FFFE) begin
      nfail++; $display("FAIL mulu prodh: got %h expected fffffffe", ph[0]);
    end
    nchk++;
    if (pl[0] !== 32'h0000_0001) begin
      nfail++; $display("FAIL mulu prodl: got %h expected 00000001", pl[0]);
    end
    nchk++;
    if (lat[0] !== 34) begin
      nfail++; $display("FAIL mulu latency: got %0d expected 34", lat[0]);
    end
    nchk++;
    if (bcnt[0] !== 33) begin
      nfail++; $display("FAIL mulu busy cycles: got %0d expected 33", bcnt[0]);
    end
  endtask

  task automatic test_signed();
    logic        tm [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] tx [3] = '{32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] ty [3] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    logic [31:0] eh [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] el [3] = '{32'h8000_0000, 32'hFFFF_FFFD, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(tm[i], 1'b1, tx[i], ty[i]);
      nchk++;
      if ({ph[0], pl[0], dz[0]} !== {eh[i], el[i], 1'b0}) begin
        nfail++;
        $display("FAIL signed vec%0d: got %h_%h dbz=%b expected %h_%h dbz=0",
                 i, ph[0], pl[0], dz[0], eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    for (int s = 0; s < 2; s++) begin
      run_op(1'b0, 1'(s), 32'hABCD_EF01, 32'h0);
      nchk++;
      if ({ph[0], pl[0], dz[0]} !== {32'hABCD_EF01, 32'hFFFF_FFFF, 1'b1}) begin
        nfail++;
        $display("FAIL divzero s%0d result: got %h_%h dbz=%b expected abcdef01_ffffffff dbz=1",
                 s, ph[0], pl[0], dz[0]);
      end
      nchk++;
      if (lat[0] !== 1 || bcnt[0] !== 0) begin
        nfail++;
        $display("FAIL divzero s%0d timing: got lat=%0d busy=%0d expected lat=1 busy=0",
                 s, lat[0], bcnt[0]);
      end
    end
    run_op(1'b0, 1'b0, 32'h0000_0064, 32'h0000_0007);
    nchk++;
    if ({ph[0], pl[0], dz[0]} !== {32'h0000_0002, 32'h0000_000E, 1'b0}) begin
      nfail++;
      $display("FAIL div after zero: got %h_%h dbz=%b expected 00000002_0000000e dbz=0",
               ph[0], pl[0], dz[0]);
    end
  endtask

  task automatic test_abort();
    run_op(1'b1, 1'b0, 32'h3, 32'h5);
    nchk++;
    if ({ph[0], pl[0]} !== 64'hF) begin
      nfail++; $display("FAIL abort prior result: got %h_%h expected 0_f", ph[0], pl[0]);
    end
    @(negedge clk);
    multdivb = 1'b1; signedop = 1'b0; xin = 32'h1234_5678; yin = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    nchk++;
    if ({bs[0], dn[0], ph[0], pl[0]} !== {2'b00, 64'hF}) begin
      nfail++;
      $display("FAIL abort state: got busy=%b done=%b %h_%h expected busy=0 done=0 0_f",
               bs[0], dn[0], ph[0], pl[0]);
    end
    repeat (40) @(negedge clk);
    nchk++;
    if ({bs[0], dn[0], ph[0], pl[0]} !== {2'b00, 64'hF}) begin
      nfail++;
      $display("FAIL abort later: got busy=%b done=%b %h_%h expected busy=0 done=0 0_f",
               bs[0], dn[0], ph[0], pl[0]);
    end
  endtask

  task automatic test_start_ignored();
    int l = -1;
    @(negedge clk);
    multdivb = 1'b1; signedop = 1'b0; xin = 32'h0000_1234; yin = 32'h0000_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; multdivb = 1'b0; xin = 32'hFFFF_FFFF; yin = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    for (int k = 6; k <= 60; k++) begin
      if (dn[0]) begin
        l = k;
        break;
      end
      @(negedge clk);
    end
    nchk++;
    if (l !== 34) begin
      nfail++; $display("FAIL ignored start latency: got %0d expected 34", l);
    end
    nchk++;
    if ({ph[0], pl[0]} !== 64'h0000_0000_0626_0060) begin
      nfail++;
      $display("FAIL ignored start result: got %h_%h expected 00000000_06260060", ph[0], pl[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    multdivb = 1'b1; signedop = 1'b1; xin = 32'h2345_6789; yin = 32'hABCD_EF01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 6; g++) begin
      nchk++;
      if ({ph[g], pl[g], dn[g], bs[g], dz[g]} !== 67'h0) begin
        nfail++;
        $display("FAIL reset mid g%0d: got h=%h l=%h done=%b busy=%b dbz=%b expected all zero",
                 g, ph[g], pl[g], dn[g], bs[g], dz[g]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] c32 [9] = '{32'h0, 32'h1, 32'h2, 32'h7FFF_FFFF, 32'h8000_0000,
                             32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2345_6789, 32'hABCD_EF01};
    logic [31:0] c8 [7]  = '{32'h0, 32'h1, 32'h2, 32'h7F, 32'h80, 32'hFE, 32'hFF};
    logic [31:0] a, b, mask;
    logic [63:0] e;
    logic        mul, sgn, zd;
    int          el, eb;
    for (int pass = 0; pass < 2; pass++) begin
      for (int op = 0; op < 4; op++) begin
        mul = op[1];
        sgn = op[0];
        for (int i = 0; i < ((pass == 0) ? 9 : 7); i++) begin
          for (int j = 0; j < ((pass == 0) ? 9 : 7); j++) begin
            a = (pass == 0) ? c32[i] : c8[i];
            b = (pass == 0) ? c32[j] : c8[j];
            run_op(mul, sgn, a, b);
            for (int g = 0; g < 6; g++) begin
              mask = (width_of(g) == 32) ? 32'hFFFF_FFFF : 32'hFF;
              e    = model(mul, sgn, a, b, width_of(g));
              zd   = !mul && ((b & mask) == 32'h0);
              el   = zd ? 1 : n_of(g) + 2;
              eb   = zd ? 0 : n_of(g) + 1;
              nchk++;
              if ({ph[g], pl[g]} !== e) begin
                nfail++;
                $display("FAIL sweep result g%0d op%0d a=%h b=%h: got %h_%h expected %h_%h",
                         g, op, a, b, ph[g], pl[g], e[63:32], e[31:0]);
              end
              nchk++;
              if (dz[g] !== zd) begin
                nfail++;
                $display("FAIL sweep dbz g%0d op%0d a=%h b=%h: got %b expected %b",
                         g, op, a, b, dz[g], zd);
              end
              nchk++;
              if (lat[g] !== el || bcnt[g] !== eb) begin
                nfail++;
                $display("FAIL sweep timing g%0d op%0d a=%h b=%h: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                         g, op, a, b, lat[g], bcnt[g], el, eb);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        pm, ps;
    logic [31:0] pa, pb;
    logic [63:0] e;
    int          got = 0;
    int          t;
    pm = 1'($urandom_range(0, 1)); ps = 1'($urandom_range(0, 1));
    pa = $urandom(); pb = $urandom();
    if (!pm && pb == 32'h0) pb = 32'h1;
    @(negedge clk);
    multdivb = pm; signedop = ps; xin = pa; yin = pb; start = 1'b1;
    @(negedge clk);
    while (got < 100) begin
      t = 0;
      while (!dn[0] && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!dn[0]) begin
        nchk++; nfail++;
        $display("FAIL b2b timeout op%0d: got done=0 expected done=1", got);
        break;
      end
      e = model(pm, ps, pa, pb, 32);
      nchk++;
      if ({ph[0], pl[0]} !== e) begin
        nfail++;
        $display("FAIL b2b result op%0d: got %h_%h expected %h_%h",
                 got, ph[0], pl[0], e[63:32], e[31:0]);
      end
      got++;
      if (got == 100) begin
        start = 1'b0;
        break;
      end
      pm = 1'($urandom_range(0, 1)); ps = 1'($urandom_range(0, 1));
      pa = $urandom(); pb = $urandom();
      if (!pm && pb == 32'h0) pb = 32'h1;
      multdivb = pm; signedop = ps; xin = pa; yin = pb;
      @(negedge clk);
      nchk++;
      if ({dn[0], bs[0], ph[0], pl[0]} !== {2'b01, e}) begin
        nfail++;
        $display("FAIL b2b relaunch op%0d: got done=%b busy=%b %h_%h expected done=0 busy=1 %h_%h",
                 got, dn[0], bs[0], ph[0], pl[0], e[63:32], e[31:0]);
      end
    end
    start = 1'b0;
    nchk++;
    if (got !== 100) begin
      nfail++; $display("FAIL b2b count: got %0d expected 100", got);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; multdivb = 1'b0; signedop = 1'b0;
    xin = '0; yin = '0;
    test_reset();
    test_mul_unsigned();
    test_signed();
    test_div_by_zero();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
